// File: rtl/ldpc_bf_iter_ctrl_if.sv
// Handshake/status bundle between the bit-flipping iteration controller,
// the syndrome stage and the flip engine.
interface ldpc_bf_iter_ctrl_if #(
    parameter int SUM_BITS  = 9,
    parameter int ITER_BITS = 6
);
    logic                 start;
    logic                 syn_valid;
    logic [SUM_BITS-1:0]  syn_weight;
    logic                 flip_req;
    logic                 flip_ack;
    logic                 busy;
    logic                 done;
    logic                 success;
    logic [ITER_BITS-1:0] iter_cnt;
    logic [SUM_BITS-1:0]  final_weight;
    logic [SUM_BITS-1:0]  best_weight;

    modport master (
        output start, syn_valid, syn_weight, flip_ack,
        input  flip_req, busy, done, success, iter_cnt, final_weight, best_weight
    );

    modport slave (
        input  start, syn_valid, syn_weight, flip_ack,
        output flip_req, busy, done, success, iter_cnt, final_weight, best_weight
    );
endinterface

// File: rtl/ldpc_bf_iter_ctrl.sv
// Iteration controller for the bit-flipping LDPC decoder: converge / give up / flip again.
// Optional stall termination is enabled by defining LDPC_BF_STALL_DETECT_EN.
module ldpc_bf_iter_ctrl #(
    parameter int SUM_BITS    = 9,
    parameter int ITER_BITS   = 6,
    parameter int MAX_ITER    = 20,
    parameter int STALL_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    ldpc_bf_iter_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_SYN = 2'd1;
    localparam logic [1:0] FLIP     = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    localparam logic [ITER_BITS-1:0] MAX_CNT = ITER_BITS'(MAX_ITER);

    function automatic logic [SUM_BITS-1:0] umin(input logic [SUM_BITS-1:0] a,
                                                 input logic [SUM_BITS-1:0] b);
        return (b < a) ? b : a;
    endfunction

    logic [1:0]           state;
    logic                 done;
    logic                 success;
    logic [ITER_BITS-1:0] iter_cnt;
    logic [SUM_BITS-1:0]  final_weight;
    logic [SUM_BITS-1:0]  best_weight;

`ifdef LDPC_BF_STALL_DETECT_EN
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_next;
    logic               stall_hit;

    // Improvement is judged against the best weight before this evaluation updates it.
    always_comb begin
        stall_next = (bus.syn_weight < best_weight) ? '0 : stall_cnt + STALL_W'(1);
        stall_hit  = (stall_next == STALL_W'(STALL_LIMIT));
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            done         <= 1'b0;
            success      <= 1'b0;
            iter_cnt     <= '0;
            final_weight <= '0;
            best_weight  <= '1;
`ifdef LDPC_BF_STALL_DETECT_EN
            stall_cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state        <= WAIT_SYN;
                        iter_cnt     <= '0;
                        best_weight  <= '1;
                        success      <= 1'b0;
                        final_weight <= '0;
`ifdef LDPC_BF_STALL_DETECT_EN
                        stall_cnt    <= '0;
`endif
                    end
                end
                WAIT_SYN: begin
                    if (bus.syn_valid) begin
                        best_weight <= umin(best_weight, bus.syn_weight);
                        // Priority: convergence, then stall, then iteration budget.
                        if (bus.syn_weight == '0) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            success      <= 1'b1;
                            final_weight <= '0;
                        end
`ifdef LDPC_BF_STALL_DETECT_EN
                        else if (stall_hit) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            success      <= 1'b0;
                            final_weight <= bus.syn_weight;
                        end
`endif
                        else if (iter_cnt == MAX_CNT) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            success      <= 1'b0;
                            final_weight <= bus.syn_weight;
                        end else begin
                            state <= FLIP;
                        end
`ifdef LDPC_BF_STALL_DETECT_EN
                        if (bus.syn_weight != '0) begin
                            stall_cnt <= stall_next;
                        end
`endif
                    end
                end
                FLIP: begin
                    if (bus.flip_ack) begin
                        iter_cnt <= iter_cnt + ITER_BITS'(1);
                        state    <= WAIT_SYN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from state so flip_req and busy fall with the asynchronous reset.
    assign bus.flip_req     = (state == FLIP);
    assign bus.busy         = (state == WAIT_SYN) || (state == FLIP);
    assign bus.done         = done;
    assign bus.success      = success;
    assign bus.iter_cnt     = iter_cnt;
    assign bus.final_weight = final_weight;
    assign bus.best_weight  = best_weight;
endmodule

// File: tb/tb_ldpc_bf_iter_ctrl.sv
// Scoreboard bench for ldpc_bf_iter_ctrl: directed decodes, expected terminations
// queued at stimulus time and checked by a monitor on each done pulse.
module tb_ldpc_bf_iter_ctrl;
    localparam int SB = 9;
    localparam int IB = 6;

    typedef struct packed {
        logic          success;
        logic [SB-1:0] final_weight;
        logic [IB-1:0] iter_cnt;
        logic [SB-1:0] best_weight;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_fail = 0;
    int   flip_eps = 0;
    int   base;
    logic prev_req = 1'b0;
    exp_t sbq[$];
    logic [SB-1:0] wv[8];

    always #5 clk = ~clk;

    ldpc_bf_iter_ctrl_if #(.SUM_BITS(SB), .ITER_BITS(IB)) bus ();

    ldpc_bf_iter_ctrl #(
        .SUM_BITS(SB), .ITER_BITS(IB), .MAX_ITER(4), .STALL_LIMIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected termination record.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.flip_req && !prev_req) flip_eps++;
            prev_req = bus.flip_req;
            if (bus.done === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("success",      {31'd0, bus.success},   {31'd0, e.success});
                    chk("final_weight", {23'd0, bus.final_weight}, {23'd0, e.final_weight});
                    chk("iter_cnt",     {26'd0, bus.iter_cnt},  {26'd0, e.iter_cnt});
                    chk("best_weight",  {23'd0, bus.best_weight}, {23'd0, e.best_weight});
                end
            end
        end else begin
            prev_req = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_syn(input logic [SB-1:0] w);
        bus.syn_valid  = 1'b1;
        bus.syn_weight = w;
        tick();
        bus.syn_valid  = 1'b0;
    endtask

    task automatic flip_pass();
        tick();
        bus.flip_ack = 1'b1;
        tick();
        bus.flip_ack = 1'b0;
        chk("flip_req_drop", {31'd0, bus.flip_req}, 0);
    endtask

    task automatic run_seq(input int n);
        for (int i = 0; i < n; i++) begin
            send_syn(wv[i]);
            if (i == n - 1) begin
                chk("done_latency", {31'd0, bus.done}, 1);
            end else begin
                chk("flip_req_on", {31'd0, bus.flip_req}, 1);
                flip_pass();
            end
        end
    endtask

    initial begin
        int npass;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.syn_valid = 1'b0;
        bus.syn_weight = '0;
        bus.flip_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flip_req", {31'd0, bus.flip_req}, 0);
        chk("rst_busy",     {31'd0, bus.busy}, 0);
        chk("rst_done",     {31'd0, bus.done}, 0);
        chk("rst_success",  {31'd0, bus.success}, 0);
        chk("rst_iter",     {26'd0, bus.iter_cnt}, 0);
        chk("rst_final",    {23'd0, bus.final_weight}, 0);
        chk("rst_best",     {23'd0, bus.best_weight}, 511);
        rst = 1'b1;
        tick();

        // Immediate convergence, no flip pass.
        base = flip_eps;
        sbq.push_back('{1'b1, 9'd0, 6'd0, 9'd0});
        do_start();
        chk("busy_after_start", {31'd0, bus.busy}, 1);
        wv[0] = 0;
        run_seq(1);
        chk("t1_flips", flip_eps - base, 0);
        tick();
        chk("done_one_cycle", {31'd0, bus.done}, 0);
        chk("success_hold",   {31'd0, bus.success}, 1);

        // 12,7,3,0: three flip passes.
        base = flip_eps;
        sbq.push_back('{1'b1, 9'd0, 6'd3, 9'd0});
        do_start();
        wv[0] = 12; wv[1] = 7; wv[2] = 3; wv[3] = 0;
        run_seq(4);
        chk("t2_flips", flip_eps - base, 3);

        // Constant weight 5: budget exhausted (or stall detected first).
`ifdef LDPC_BF_STALL_DETECT_EN
        npass = 3;
`else
        npass = 4;
`endif
        base = flip_eps;
        sbq.push_back('{1'b0, 9'd5, IB'(npass), 9'd5});
        do_start();
        for (int i = 0; i <= npass; i++) wv[i] = 5;
        run_seq(npass + 1);
        chk("t3_flips", flip_eps - base, npass);

        // Weight 0 exactly at iter_cnt==MAX_ITER: convergence wins.
        sbq.push_back('{1'b1, 9'd0, 6'd4, 9'd0});
        do_start();
        wv[0] = 8; wv[1] = 7; wv[2] = 6; wv[3] = 5; wv[4] = 0;
        run_seq(5);

        // start and syn_valid together in DONE: start wins.
        bus.start = 1'b1;
        bus.syn_valid = 1'b1;
        bus.syn_weight = 0;
        tick();
        bus.start = 1'b0;
        bus.syn_valid = 1'b0;
        chk("sd_busy",    {31'd0, bus.busy}, 1);
        chk("sd_done",    {31'd0, bus.done}, 0);
        chk("sd_success", {31'd0, bus.success}, 0);
        chk("sd_best",    {23'd0, bus.best_weight}, 511);
        sbq.push_back('{1'b1, 9'd0, 6'd0, 9'd0});
        wv[0] = 0;
        run_seq(1);

        // Ignored inputs: ack in WAIT_SYN, start/syn_valid in FLIP.
        sbq.push_back('{1'b1, 9'd0, 6'd1, 9'd0});
        do_start();
        bus.flip_ack = 1'b1;
        tick();
        bus.flip_ack = 1'b0;
        chk("ign_ack_busy", {31'd0, bus.busy}, 1);
        chk("ign_ack_req",  {31'd0, bus.flip_req}, 0);
        chk("ign_ack_iter", {26'd0, bus.iter_cnt}, 0);
        send_syn(6);
        chk("ign_flip_enter", {31'd0, bus.flip_req}, 1);
        bus.start = 1'b1;
        bus.syn_valid = 1'b1;
        bus.syn_weight = 0;
        tick();
        bus.start = 1'b0;
        bus.syn_valid = 1'b0;
        chk("ign_flip_req",  {31'd0, bus.flip_req}, 1);
        chk("ign_flip_iter", {26'd0, bus.iter_cnt}, 0);
        chk("ign_flip_best", {23'd0, bus.best_weight}, 6);
        chk("ign_flip_done", {31'd0, bus.done}, 0);
        flip_pass();
        chk("ign_iter_inc", {26'd0, bus.iter_cnt}, 1);
        send_syn(0);
        chk("ign_done", {31'd0, bus.done}, 1);

        // Asynchronous reset during the second flip request.
        do_start();
        send_syn(9);
        flip_pass();
        send_syn(8);
        chk("pre_rst_req",  {31'd0, bus.flip_req}, 1);
        chk("pre_rst_iter", {26'd0, bus.iter_cnt}, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_req",  {31'd0, bus.flip_req}, 0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 0);
        chk("mid_rst_iter", {26'd0, bus.iter_cnt}, 0);
        chk("mid_rst_best", {23'd0, bus.best_weight}, 511);
        tick();
        rst = 1'b1;
        tick();
        sbq.push_back('{1'b1, 9'd0, 6'd1, 9'd0});
        do_start();
        wv[0] = 4; wv[1] = 0;
        run_seq(2);

`ifdef LDPC_BF_STALL_DETECT_EN
        // Stall: 10,8,8,9,8 terminates on the fifth evaluation.
        sbq.push_back('{1'b0, 9'd8, 6'd4, 9'd8});
        do_start();
        wv[0] = 10; wv[1] = 8; wv[2] = 8; wv[3] = 9; wv[4] = 8;
        run_seq(5);
`endif

        repeat (3) tick();
        chk("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/ldpc_bf_iter_ctrl.md
Name: ldpc_bf_iter_ctrl

Overview:
- Iteration controller for the bit-flipping LDPC decoder. It sits directly downstream of the syndrome-weight adder and consumes its weight output.
- Each decode is framed by a start pulse. On every syndrome evaluation it decides one of three outcomes:
  - converge: weight is zero;
  - give up: iteration budget exhausted;
  - continue: request another flip pass from the flip engine.
- It reports the iteration count, the final weight and the best weight seen.

Parameters:
SUM_BITS, 9, width of syndrome weight input (matches adder output)
ITER_BITS, 6, width of iteration counter
MAX_ITER, 20, maximum flip iterations before declaring failure (1..2^ITER_BITS-1)
STALL_LIMIT, 3, consecutive non-improving iterations tolerated (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a decode; ignored unless state is IDLE or DONE
syn_valid  input  1  syn_weight is valid this cycle (one-cycle pulse from the syndrome stage)
syn_weight  input  SUM_BITS  syndrome weight from the adder
flip_req  output  1  level; asks the flip engine for one flip pass; held until flip_ack
flip_ack  input  1  flip pass complete; sampled only while flip_req=1
busy  output  1  high in WAIT_SYN and FLIP
done  output  1  one-cycle pulse on entry to DONE
success  output  1  1 = converged (weight 0); valid from done until next start
iter_cnt  output  ITER_BITS  flip passes completed in the current decode
final_weight  output  SUM_BITS  weight at termination
best_weight  output  SUM_BITS  minimum weight seen in the current decode

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0, except best_weight, which is all-ones.
- States: IDLE, WAIT_SYN, FLIP, DONE. One state transition per clk.
- IDLE/DONE, start=1:
  - Next state WAIT_SYN.
  - iter_cnt<=0, best_weight<=all-ones, success<=0, final_weight<=0.
- WAIT_SYN, syn_valid=1:
  - best_weight<=min(best_weight, syn_weight) in the same cycle.
  - syn_weight==0: go to DONE; success<=1, final_weight<=0.
  - Else if iter_cnt==MAX_ITER: go to DONE; success<=0, final_weight<=syn_weight.
  - Else go to FLIP.
- WAIT_SYN, syn_valid=0: hold.
- FLIP:
  - flip_req=1 for every cycle in FLIP.
  - On flip_ack=1: iter_cnt<=iter_cnt+1, return to WAIT_SYN.
  - flip_req is 0 in the cycle after ack.
  - flip_ack arriving in the same cycle flip_req first rises is accepted. FLIP therefore lasts a minimum of 1 cycle.
- DONE:
  - done=1 for the entry cycle only.
  - success, final_weight, iter_cnt and best_weight hold until the next start.
- Latency: syn_valid with weight 0 gives done one cycle later, i.e. done asserts on the following clk edge.
- Ignored inputs:
  - start while busy: no effect.
  - syn_valid outside WAIT_SYN: no effect.
  - flip_ack outside FLIP: no effect.
- Simultaneous events:
  - syn_valid with weight 0 and iter_cnt==MAX_ITER: convergence wins (success=1).
  - start and syn_valid in the same cycle in DONE: start wins; that syn_valid is dropped.
- Arithmetic:
  - iter_cnt never exceeds MAX_ITER, so it never wraps.
  - best_weight comparison is unsigned, full SUM_BITS width.
- Reset mid-decode: immediate return to IDLE with reset values. flip_req drops asynchronously.

Optional Feature:
- Macro: LDPC_BF_STALL_DETECT_EN.
- Enabled:
  - An internal stall counter (clog2(STALL_LIMIT+1) bits) clears on start.
  - In WAIT_SYN with syn_valid and nonzero weight:
    - syn_weight < best_weight (before update): counter clears.
    - Otherwise the counter increments.
  - If the incremented value reaches STALL_LIMIT: go to DONE with success=0 and final_weight=syn_weight.
  - Stall is checked after the zero-weight check and before the MAX_ITER check.
- Disabled: no stall counter; termination only on weight 0 or MAX_ITER.

Test Plan:
- Reset then start, first syn_valid weight=0 -> done pulse next cycle; success=1, iter_cnt=0, final_weight=0, flip_req never asserted.
- Start; weights 12,7,3,0, each flip_ack one cycle after flip_req -> three flip_req episodes; done with iter_cnt=3, best_weight=0, success=1.
- MAX_ITER=4, weights always 5 (feature off) -> four flip passes; fifth syn_valid gives done; success=0, final_weight=5, iter_cnt=4.
- Pull rst low while flip_req=1 in the second iteration -> flip_req, busy and iter_cnt go to 0 immediately; best_weight goes to 511; a later start behaves normally.
- Start and syn_valid asserted while busy; flip_ack asserted in WAIT_SYN -> no state change, no iter_cnt increment.
- LDPC_BF_STALL_DETECT_EN, STALL_LIMIT=3, weights 10,8,8,9,8 -> stall count 0,1,2,3; done after the fifth evaluation with success=0, final_weight=8, iter_cnt=4, best_weight=8.
